// File: rtl/gpa_fhdo_pkg.sv
// gpa_fhdo_pkg: shared constants and the frame layout for the GPA-FHDO SPI responder.
// Holds the register map addresses, DEVICE_ID, the soft-reset trigger code and the
// frame length. Optional feature macro used by the top: GPA_FHDO_RESP_READBACK_EN.
package gpa_fhdo_pkg;

   localparam int unsigned FRAME_LEN = 24;
   localparam int unsigned DATA_W    = 16;
   localparam int unsigned ADDR_W    = 4;
   localparam int unsigned CNT_W     = 5;
   localparam int unsigned NUM_DAC   = 4;
   localparam int unsigned IDX_W     = 2;
   localparam int unsigned TRIG_LOAD_BIT = 4;

   localparam logic [ADDR_W-1:0] ADDR_DEVICE_ID = 4'h1;
   localparam logic [ADDR_W-1:0] ADDR_SYNC      = 4'h2;
   localparam logic [ADDR_W-1:0] ADDR_CONFIG    = 4'h3;
   localparam logic [ADDR_W-1:0] ADDR_TRIGGER   = 4'h5;
   localparam logic [ADDR_W-1:0] ADDR_DAC0      = 4'h8;
   localparam logic [ADDR_W-1:0] ADDR_DAC1      = 4'h9;
   localparam logic [ADDR_W-1:0] ADDR_DAC2      = 4'hA;
   localparam logic [ADDR_W-1:0] ADDR_DAC3      = 4'hB;

   localparam logic [DATA_W-1:0] DEVICE_ID       = 16'h2158;
   localparam logic [3:0]        SOFT_RESET_CODE = 4'b1010;

   // One 24-bit SPI frame, MSB first on the wire.
   typedef struct packed {
      logic              rw;     // 1 = read
      logic [2:0]        rsvd;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } frame_t;

endpackage

// File: rtl/gpa_fhdo_spi_responder_edge.sv
// spi_edge_sync: 2-flop synchronizer for one asynchronous input plus rise/fall
// detection on the synchronized level.
// Ports: clk; async_i (raw pin); sync_o (synchronized level, registered);
//        rise_c / fall_c (combinational one-cycle edge strobes).
// The flops carry no reset on purpose: they keep tracking the pin during reset, so a
// pin already low when reset releases never shows up as a false falling edge.
module spi_edge_sync (
   input  logic clk,
   input  logic async_i,
   output logic sync_o,
   output logic rise_c,
   output logic fall_c
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   // Synchronizer chain plus one delay stage for edge detection.
   always_comb begin
      meta_d = async_i;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   always_ff @(posedge clk) begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
   end

   assign sync_o = sync_q;
   assign rise_c = sync_q & ~prev_q;
   assign fall_c = ~sync_q & prev_q;

endmodule

// File: rtl/gpa_fhdo_spi_responder.sv
// gpa_fhdo_spi_responder: SPI slave emulating the GPA-FHDO 4-channel DAC register file.
// Ports: clk, rst (sync, active high); sclk_i, csn_i, sdi_i, ldacn_i (async SPI / load
//        pins); sdo_o (readback data); vout0_o..vout3_o (active DAC codes);
//        frame_o (pulse on committed 24-bit frame); err_o (pulse on discarded frame).
// Macro GPA_FHDO_RESP_READBACK_EN enables register readback on sdo_o; without it
// sdo_o is tied low.
module gpa_fhdo_spi_responder
   import gpa_fhdo_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        sclk_i,
   input  logic        csn_i,
   input  logic        sdi_i,
   input  logic        ldacn_i,
   output logic        sdo_o,
   output logic [15:0] vout0_o,
   output logic [15:0] vout1_o,
   output logic [15:0] vout2_o,
   output logic [15:0] vout3_o,
   output logic        frame_o,
   output logic        err_o
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SHIFT  = 2'd1;
   localparam logic [1:0] ST_COMMIT = 2'd2;

   logic sclk_s, sclk_rise, sclk_fall;
   logic csn_s, csn_rise, csn_fall;
   logic sdi_s, sdi_rise, sdi_fall;
   logic ldacn_s, ldacn_rise, ldacn_fall;
   logic unused_sync;

   spi_edge_sync u_sync_sclk  (.clk(clk), .async_i(sclk_i),  .sync_o(sclk_s),  .rise_c(sclk_rise),  .fall_c(sclk_fall));
   spi_edge_sync u_sync_csn   (.clk(clk), .async_i(csn_i),   .sync_o(csn_s),   .rise_c(csn_rise),   .fall_c(csn_fall));
   spi_edge_sync u_sync_sdi   (.clk(clk), .async_i(sdi_i),   .sync_o(sdi_s),   .rise_c(sdi_rise),   .fall_c(sdi_fall));
   spi_edge_sync u_sync_ldacn (.clk(clk), .async_i(ldacn_i), .sync_o(ldacn_s), .rise_c(ldacn_rise), .fall_c(ldacn_fall));

   assign unused_sync = ^{sclk_s, sclk_rise, sdi_rise, sdi_fall, ldacn_s, ldacn_rise};

   logic [1:0]                      state_q, state_d;
   logic [CNT_W-1:0]                cnt_q, cnt_d;
   logic [FRAME_LEN-1:0]            shreg_q, shreg_d;
   logic [NUM_DAC-1:0]              sync_en_q, sync_en_d;
   logic [DATA_W-1:0]               config_q, config_d;
   logic [NUM_DAC-1:0][DATA_W-1:0]  buf_q, buf_d;
   logic [NUM_DAC-1:0][DATA_W-1:0]  vout_q, vout_d;
   logic                            frame_q, frame_d;
   logic                            err_q, err_d;

   frame_t          cmd;
   logic            commit_c, wr_c, trig_c, soft_rst_c, dac_wr_c, load_c;
   logic [IDX_W-1:0] dac_idx_c;

   assign cmd = frame_t'(shreg_q);

   // Decode of the frame being committed; frame_q marks a valid length in COMMIT.
   always_comb begin
      commit_c   = (state_q == ST_COMMIT) && frame_q;
      wr_c       = commit_c && !cmd.rw;
      trig_c     = wr_c && (cmd.addr == ADDR_TRIGGER);
      soft_rst_c = trig_c && (cmd.data[3:0] == SOFT_RESET_CODE);
      dac_wr_c   = wr_c && (cmd.addr[3:2] == 2'b10);
      dac_idx_c  = cmd.addr[IDX_W-1:0];
      load_c     = ldacn_fall || (trig_c && cmd.data[TRIG_LOAD_BIT]);
   end

   // Frame FSM, register file and DAC outputs.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shreg_d   = shreg_q;
      sync_en_d = sync_en_q;
      config_d  = config_q;
      buf_d     = buf_q;
      vout_d    = vout_q;
      frame_d   = 1'b0;
      err_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (csn_fall) begin
               state_d = ST_SHIFT;
               cnt_d   = '0;
            end
         end
         ST_SHIFT: begin
            if (csn_rise) begin
               state_d = ST_COMMIT;
               frame_d = (cnt_q == CNT_W'(FRAME_LEN));
               err_d   = !frame_d;
            end else if (sclk_fall && !csn_s) begin
               shreg_d = {shreg_q[FRAME_LEN-2:0], sdi_s};
               if (cnt_q != '1) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_COMMIT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase

      if (wr_c) begin
         case (cmd.addr)
            ADDR_SYNC:   sync_en_d = cmd.data[NUM_DAC-1:0];
            ADDR_CONFIG: config_d  = cmd.data;
            default:     ;
         endcase
      end

      if (dac_wr_c) begin
         buf_d[dac_idx_c] = cmd.data;
         if (!sync_en_q[dac_idx_c]) begin
            vout_d[dac_idx_c] = cmd.data;
         end
      end

      // Load from buf_d so a write committing in the same cycle as the strobe wins.
      if (load_c) begin
         for (int i = 0; i < NUM_DAC; i++) begin
            if (sync_en_q[IDX_W'(i)]) begin
               vout_d[IDX_W'(i)] = buf_d[IDX_W'(i)];
            end
         end
      end

      if (soft_rst_c) begin
         state_d   = ST_IDLE;
         cnt_d     = '0;
         shreg_d   = '0;
         sync_en_d = '0;
         config_d  = '0;
         buf_d     = '0;
         vout_d    = '0;
         frame_d   = 1'b0;
         err_d     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         shreg_q   <= '0;
         sync_en_q <= '0;
         config_q  <= '0;
         buf_q     <= '0;
         vout_q    <= '0;
         frame_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shreg_q   <= shreg_d;
         sync_en_q <= sync_en_d;
         config_q  <= config_d;
         buf_q     <= buf_d;
         vout_q    <= vout_d;
         frame_q   <= frame_d;
         err_q     <= err_d;
      end
   end

   assign vout0_o = vout_q[0];
   assign vout1_o = vout_q[1];
   assign vout2_o = vout_q[2];
   assign vout3_o = vout_q[3];
   assign frame_o = frame_q;
   assign err_o   = err_q;

`ifdef GPA_FHDO_RESP_READBACK_EN
   logic                 rb_arm_q, rb_arm_d;
   logic                 tx_act_q, tx_act_d;
   logic                 sdo_q, sdo_d;
   logic [FRAME_LEN-1:0] rb_word_q, rb_word_d;
   logic [FRAME_LEN-1:0] tx_q, tx_d;
   logic [DATA_W-1:0]    rd_data_c;

   // Register read mux, sampled when a read frame commits.
   always_comb begin
      rd_data_c = '0;
      case (cmd.addr)
         ADDR_DEVICE_ID: rd_data_c = DEVICE_ID;
         ADDR_SYNC:      rd_data_c = DATA_W'(sync_en_q);
         ADDR_CONFIG:    rd_data_c = config_q;
         ADDR_DAC0:      rd_data_c = buf_q[0];
         ADDR_DAC1:      rd_data_c = buf_q[1];
         ADDR_DAC2:      rd_data_c = buf_q[2];
         ADDR_DAC3:      rd_data_c = buf_q[3];
         default:        rd_data_c = '0;
      endcase
   end

   // A committed read arms one readback word, consumed by the next frame.
   always_comb begin
      rb_arm_d  = rb_arm_q;
      rb_word_d = rb_word_q;
      tx_act_d  = tx_act_q;
      tx_d      = tx_q;
      sdo_d     = sdo_q;

      if ((state_q == ST_IDLE) && csn_fall) begin
         tx_d     = rb_word_q;
         tx_act_d = rb_arm_q;
         rb_arm_d = 1'b0;
         sdo_d    = 1'b0;
      end else if (state_q == ST_SHIFT) begin
         if (csn_rise) begin
            tx_act_d = 1'b0;
            sdo_d    = 1'b0;
         end else if (sclk_rise && !csn_s && tx_act_q) begin
            sdo_d = tx_q[FRAME_LEN-1];
            tx_d  = {tx_q[FRAME_LEN-2:0], 1'b0};
         end
      end

      if (commit_c && cmd.rw) begin
         rb_arm_d  = 1'b1;
         rb_word_d = {cmd.rw, cmd.rsvd, cmd.addr, rd_data_c};
      end

      if (soft_rst_c) begin
         rb_arm_d = 1'b0;
         tx_act_d = 1'b0;
         sdo_d    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rb_arm_q  <= 1'b0;
         rb_word_q <= '0;
         tx_act_q  <= 1'b0;
         tx_q      <= '0;
         sdo_q     <= 1'b0;
      end else begin
         rb_arm_q  <= rb_arm_d;
         rb_word_q <= rb_word_d;
         tx_act_q  <= tx_act_d;
         tx_q      <= tx_d;
         sdo_q     <= sdo_d;
      end
   end

   assign sdo_o = sdo_q;
`else
   assign sdo_o = 1'b0;
`endif

endmodule

// File: tb/tb_gpa_fhdo_spi_responder.sv
// tb_gpa_fhdo_spi_responder: directed self-checking bench for gpa_fhdo_spi_responder.
// Drives SPI frames bit by bit (12 clk per sclk period) and checks DAC outputs,
// frame/error pulse counts and, when GPA_FHDO_RESP_READBACK_EN is defined, readback.
module tb_gpa_fhdo_spi_responder;

   localparam int HALF = 6;

   logic        clk = 1'b0;
   logic        rst, sclk, csn, sdi, ldacn;
   logic        sdo, frame, err;
   logic [15:0] v0, v1, v2, v3;

   int total = 0;
   int bad   = 0;
   int frame_cnt = 0;
   int err_cnt   = 0;

   always #5 clk = ~clk;

   gpa_fhdo_spi_responder dut (
      .clk(clk), .rst(rst), .sclk_i(sclk), .csn_i(csn), .sdi_i(sdi), .ldacn_i(ldacn),
      .sdo_o(sdo), .vout0_o(v0), .vout1_o(v1), .vout2_o(v2), .vout3_o(v3),
      .frame_o(frame), .err_o(err)
   );

   always @(negedge clk) begin
      if (frame) frame_cnt++;
      if (err)   err_cnt++;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One SPI bit: data set with the rising edge, slave samples on the falling edge.
   task automatic spi_bit(input logic b, inout logic [31:0] rx);
      sdi  = b;
      sclk = 1'b1;
      wait_clk(HALF);
      rx   = {rx[30:0], sdo};
      sclk = 1'b0;
      wait_clk(HALF);
   endtask

   // Full frame of nbits; ldac_dly >= 0 pulses ldacn that many clocks after csn rises.
   task automatic spi_frame(input logic [31:0] data, input int nbits, input int ldac_dly,
                            output logic [31:0] rx);
      logic [31:0] r;
      r   = '0;
      csn = 1'b0;
      wait_clk(HALF);
      for (int i = nbits - 1; i >= 0; i--) spi_bit(data[i], r);
      csn = 1'b1;
      sdi = 1'b0;
      if (ldac_dly >= 0) begin
         wait_clk(ldac_dly);
         ldacn = 1'b0;
         wait_clk(4);
         ldacn = 1'b1;
      end else begin
         wait_clk(3);
      end
      rx = r;
   endtask

   task automatic wr(input logic [23:0] w);
      logic [31:0] rx;
      spi_frame({8'h00, w}, 24, -1, rx);
      wait_clk(6);
   endtask

   task automatic test_reset();
      rst = 1'b1; csn = 1'b1; sclk = 1'b0; sdi = 1'b0; ldacn = 1'b1;
      wait_clk(5);
      total++; if (v0 !== 16'h0) begin bad++; $display("FAIL reset_vout0_in_rst: got %h want 0000", v0); end
      rst = 1'b0;
      wait_clk(5);
      total++; if (v0 !== 16'h0) begin bad++; $display("FAIL reset_vout0: got %h want 0000", v0); end
      total++; if (v1 !== 16'h0) begin bad++; $display("FAIL reset_vout1: got %h want 0000", v1); end
      total++; if (v2 !== 16'h0) begin bad++; $display("FAIL reset_vout2: got %h want 0000", v2); end
      total++; if (v3 !== 16'h0) begin bad++; $display("FAIL reset_vout3: got %h want 0000", v3); end
      total++; if (frame !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL reset_pulses: got %b%b want 00", frame, err); end
      total++; if (sdo !== 1'b0) begin bad++; $display("FAIL reset_sdo: got %b want 0", sdo); end
   endtask

   task automatic test_dac_direct();
      int f0, e0;
      f0 = frame_cnt; e0 = err_cnt;
      wr(24'h080001); wr(24'h090002); wr(24'h0A0003); wr(24'h0B0004);
      total++; if (v0 !== 16'h0001) begin bad++; $display("FAIL direct_vout0: got %h want 0001", v0); end
      total++; if (v1 !== 16'h0002) begin bad++; $display("FAIL direct_vout1: got %h want 0002", v1); end
      total++; if (v2 !== 16'h0003) begin bad++; $display("FAIL direct_vout2: got %h want 0003", v2); end
      total++; if (v3 !== 16'h0004) begin bad++; $display("FAIL direct_vout3: got %h want 0004", v3); end
      total++; if (frame_cnt - f0 !== 4) begin bad++; $display("FAIL direct_frames: got %0d want 4", frame_cnt - f0); end
      total++; if (err_cnt - e0 !== 0) begin bad++; $display("FAIL direct_errs: got %0d want 0", err_cnt - e0); end
   endtask

   task automatic test_bad_length();
      int f0, e0;
      logic [31:0] rx;
      f0 = frame_cnt; e0 = err_cnt;
      spi_frame(32'h00480BAD, 23, -1, rx); wait_clk(6);
      spi_frame(32'h010A0BAD, 25, -1, rx); wait_clk(6);
      total++; if (err_cnt - e0 !== 2) begin bad++; $display("FAIL badlen_errs: got %0d want 2", err_cnt - e0); end
      total++; if (frame_cnt - f0 !== 0) begin bad++; $display("FAIL badlen_frames: got %0d want 0", frame_cnt - f0); end
      total++; if (v0 !== 16'h0001) begin bad++; $display("FAIL badlen_vout0: got %h want 0001", v0); end
      total++; if (v2 !== 16'h0003) begin bad++; $display("FAIL badlen_vout2: got %h want 0003", v2); end
      total++; if (v3 !== 16'h0004) begin bad++; $display("FAIL badlen_vout3: got %h want 0004", v3); end
   endtask

   task automatic test_back_to_back();
      int f0;
      logic [31:0] rx;
      f0 = frame_cnt;
      spi_frame(32'h000A00AA, 24, -1, rx);
      spi_frame(32'h000B00BB, 24, -1, rx);
      wait_clk(6);
      total++; if (v2 !== 16'h00AA) begin bad++; $display("FAIL b2b_vout2: got %h want 00aa", v2); end
      total++; if (v3 !== 16'h00BB) begin bad++; $display("FAIL b2b_vout3: got %h want 00bb", v3); end
      total++; if (frame_cnt - f0 !== 2) begin bad++; $display("FAIL b2b_frames: got %0d want 2", frame_cnt - f0); end
   endtask

   task automatic test_sync_ldac();
      wr(24'h02000F);
      wr(24'h091234);
      total++; if (v1 !== 16'h0002) begin bad++; $display("FAIL sync_hold_vout1: got %h want 0002", v1); end
      ldacn = 1'b0; wait_clk(4); ldacn = 1'b1; wait_clk(4);
      total++; if (v1 !== 16'h1234) begin bad++; $display("FAIL sync_ldac_vout1: got %h want 1234", v1); end
      total++; if (v2 !== 16'h00AA) begin bad++; $display("FAIL sync_ldac_vout2: got %h want 00aa", v2); end
   endtask

   task automatic test_trigger_load();
      wr(24'h080AAA);
      total++; if (v0 !== 16'h0001) begin bad++; $display("FAIL trig_hold_vout0: got %h want 0001", v0); end
      wr(24'h050010);
      total++; if (v0 !== 16'h0AAA) begin bad++; $display("FAIL trig_load_vout0: got %h want 0aaa", v0); end
      total++; if (v1 !== 16'h1234) begin bad++; $display("FAIL trig_load_vout1: got %h want 1234", v1); end
   endtask

   task automatic test_readback();
      int f0, e0;
      logic [31:0] rx1, rx2, rx3, rx4;
      logic [23:0] exp2, exp3, exp4;
`ifdef GPA_FHDO_RESP_READBACK_EN
      exp2 = 24'h812158; exp3 = 24'h83BEEF; exp4 = 24'h891234;
`else
      exp2 = 24'h0; exp3 = 24'h0; exp4 = 24'h0;
`endif
      f0 = frame_cnt; e0 = err_cnt;
      spi_frame(32'h00810000, 24, -1, rx1);
      spi_frame(32'h00000000, 24, -1, rx2);
      wr(24'h03BEEF);
      spi_frame(32'h00830000, 24, -1, rx3);
      spi_frame(32'h00890000, 24, -1, rx3);
      spi_frame(32'h00000000, 24, -1, rx4);
      wait_clk(6);
      total++; if (rx1[23:0] !== 24'h0) begin bad++; $display("FAIL rb_unarmed: got %h want 000000", rx1[23:0]); end
      total++; if (rx2[23:0] !== exp2) begin bad++; $display("FAIL rb_device_id: got %h want %h", rx2[23:0], exp2); end
      total++; if (rx3[23:0] !== exp3) begin bad++; $display("FAIL rb_config: got %h want %h", rx3[23:0], exp3); end
      total++; if (rx4[23:0] !== exp4) begin bad++; $display("FAIL rb_dac1: got %h want %h", rx4[23:0], exp4); end
      total++; if (frame_cnt - f0 !== 6 || err_cnt - e0 !== 0) begin bad++; $display("FAIL rb_pulses: got %0d/%0d want 6/0", frame_cnt - f0, err_cnt - e0); end
   endtask

   task automatic test_soft_reset();
      logic [31:0] rx1, rx2;
      logic [23:0] exp_cfg;
      wr(24'h020002);
      wr(24'h0800FF);
      total++; if (v0 !== 16'h00FF) begin bad++; $display("FAIL soft_pre_vout0: got %h want 00ff", v0); end
      wr(24'h05000A);
      total++; if (v0 !== 16'h0) begin bad++; $display("FAIL soft_vout0: got %h want 0000", v0); end
      total++; if (v1 !== 16'h0) begin bad++; $display("FAIL soft_vout1: got %h want 0000", v1); end
      total++; if (v2 !== 16'h0 || v3 !== 16'h0) begin bad++; $display("FAIL soft_vout23: got %h %h want 0000 0000", v2, v3); end
      wr(24'h090033);
      total++; if (v1 !== 16'h0033) begin bad++; $display("FAIL soft_sync_cleared: got %h want 0033", v1); end
`ifdef GPA_FHDO_RESP_READBACK_EN
      exp_cfg = 24'h830000;
`else
      exp_cfg = 24'h0;
`endif
      spi_frame(32'h00830000, 24, -1, rx1);
      spi_frame(32'h00000000, 24, -1, rx2);
      wait_clk(6);
      total++; if (rx2[23:0] !== exp_cfg) begin bad++; $display("FAIL soft_config: got %h want %h", rx2[23:0], exp_cfg); end
   endtask

   task automatic test_rst_midframe();
      int f0, e0;
      logic [31:0] data, rx;
      wr(24'h080077);
      total++; if (v0 !== 16'h0077) begin bad++; $display("FAIL midrst_pre_vout0: got %h want 0077", v0); end
      f0 = frame_cnt; e0 = err_cnt;
      data = 32'h00080099;
      rx = '0;
      csn = 1'b0;
      wait_clk(HALF);
      for (int i = 23; i >= 12; i--) spi_bit(data[i], rx);
      rst = 1'b1; wait_clk(3); rst = 1'b0;
      for (int i = 11; i >= 0; i--) spi_bit(data[i], rx);
      csn = 1'b1; sdi = 1'b0;
      wait_clk(9);
      total++; if (v0 !== 16'h0) begin bad++; $display("FAIL midrst_vout0: got %h want 0000", v0); end
      total++; if (frame_cnt - f0 !== 0 || err_cnt - e0 !== 0) begin bad++; $display("FAIL midrst_pulses: got %0d/%0d want 0/0", frame_cnt - f0, err_cnt - e0); end
      wr(24'h080055);
      total++; if (v0 !== 16'h0055) begin bad++; $display("FAIL midrst_next_vout0: got %h want 0055", v0); end
   endtask

   task automatic test_ldac_collision();
      logic [31:0] rx;
      wr(24'h020001);
      spi_frame(32'h00080777, 24, 1, rx);
      wait_clk(6);
      total++; if (v0 !== 16'h0777) begin bad++; $display("FAIL collide_vout0: got %h want 0777", v0); end
      total++; if (v1 !== 16'h0) begin bad++; $display("FAIL collide_vout1: got %h want 0000", v1); end
   endtask

   initial begin
      test_reset();
      test_dac_direct();
      test_bad_length();
      test_back_to_back();
      test_sync_ldac();
      test_trigger_load();
      test_readback();
      test_soft_reset();
      test_rst_midframe();
      test_ldac_collision();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
